// File: rtl/result_led_ctrl.sv
// Result indicator for the Bulls and Cows guess-check path.
// Latches each scored guess and shows strikes (Green) and balls (Red) as
// thermometer bars for a hold time. A full-strike result blinks Green for a
// fixed number of periods, then holds solid Green until Clear.
module result_led_ctrl #(
   parameter int DIGITS      = 4,
   parameter int CNT_W       = 3,
   parameter int BLINK_DIV   = 25000000,
   parameter int WIN_BLINKS  = 5,
   parameter int HOLD_CYCLES = 100000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Valid,
   input  logic [CNT_W-1:0]  Strike,
   input  logic [CNT_W-1:0]  Ball,
   input  logic              Clear,
   output logic [DIGITS-1:0] Green,
   output logic [DIGITS-1:0] Red,
   output logic              Win,
   output logic              Busy
);

   localparam int DIV_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int TOG_N  = 2 * WIN_BLINKS;
   localparam int TOG_W  = $clog2(TOG_N);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BLINK_DIV - 1);
   localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(TOG_N - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DIG_C     = CNT_W'(DIGITS);
   localparam logic [DIGITS-1:0] ALL_ON    = {DIGITS{1'b1}};
   localparam logic [DIGITS-1:0] ALL_OFF   = {DIGITS{1'b0}};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHOW      = 2'd1,
      WIN_BLINK = 2'd2,
      WIN_HOLD  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DIGITS-1:0]   green_q, green_d;
   logic [DIGITS-1:0]   red_q, red_d;
   logic                win_q, win_d;
   logic                busy_q, busy_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [TOG_W-1:0]    tog_q, tog_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    s_clamp, b_clamp;

   // Thermometer code: the lowest n LEDs lit.
   function automatic logic [DIGITS-1:0] therm(input logic [CNT_W-1:0] n);
      logic [DIGITS-1:0] t;
      t = ALL_OFF;
      for (int i = 0; i < DIGITS; i++) begin
         t[i] = (CNT_W'(i) < n);
      end
      return t;
   endfunction

   // Saturate out-of-range counts at DIGITS; no error is raised.
   always_comb begin
      s_clamp = (Strike > DIG_C) ? DIG_C : Strike;
      b_clamp = (Ball > DIG_C) ? DIG_C : Ball;
   end

   // Next-state and next-output logic; Clear overrides everything.
   always_comb begin
      state_d = state_q;
      green_d = green_q;
      red_d   = red_q;
      div_d   = div_q;
      tog_d   = tog_q;
      hold_d  = hold_q;
      if (Clear) begin
         state_d = IDLE;
         green_d = ALL_OFF;
         red_d   = ALL_ON;
         div_d   = '0;
         tog_d   = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            IDLE, SHOW: begin
               if (Valid) begin
                  if (s_clamp == DIG_C) begin
                     state_d = WIN_BLINK;
                     green_d = ALL_ON;
                     red_d   = ALL_OFF;
                     div_d   = '0;
                     tog_d   = '0;
                     hold_d  = '0;
                  end else begin
                     state_d = SHOW;
                     green_d = therm(s_clamp);
                     red_d   = therm(b_clamp);
                     hold_d  = '0;
                  end
               end else if (state_q == SHOW) begin
                  if (hold_q == HOLD_LAST) begin
                     state_d = IDLE;
                     green_d = ALL_OFF;
                     red_d   = ALL_ON;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end else begin
                  green_d = ALL_OFF;
                  red_d   = ALL_ON;
               end
            end
            WIN_BLINK: begin
               red_d = ALL_OFF;
               if (div_q == DIV_LAST) begin
                  div_d = '0;
                  if (tog_q == TOG_LAST) begin
                     // Last off phase done: settle on solid green.
                     state_d = WIN_HOLD;
                     green_d = ALL_ON;
                     tog_d   = '0;
                  end else begin
                     green_d = ~green_q;
                     tog_d   = tog_q + TOG_W'(1);
                  end
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
            WIN_HOLD: begin
               green_d = ALL_ON;
               red_d   = ALL_OFF;
            end
            default: begin
               state_d = IDLE;
               green_d = ALL_OFF;
               red_d   = ALL_ON;
               div_d   = '0;
               tog_d   = '0;
               hold_d  = '0;
            end
         endcase
      end
      win_d  = (state_d == WIN_BLINK) || (state_d == WIN_HOLD);
      busy_d = (state_d == WIN_BLINK);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         green_q <= ALL_OFF;
         red_q   <= ALL_ON;
         win_q   <= 1'b0;
         busy_q  <= 1'b0;
         div_q   <= '0;
         tog_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         green_q <= green_d;
         red_q   <= red_d;
         win_q   <= win_d;
         busy_q  <= busy_d;
         div_q   <= div_d;
         tog_q   <= tog_d;
         hold_q  <= hold_d;
      end
   end

   assign Green = green_q;
   assign Red   = red_q;
   assign Win   = win_q;
   assign Busy  = busy_q;

endmodule

// File: tb/tb_result_led_ctrl.sv
// Scoreboard bench for result_led_ctrl: expected {Green,Red,Win,Busy}
// words are queued as stimulus is driven and popped one per clock.
module tb_result_led_ctrl;

   logic       clk;
   logic       rst_n;
   logic       Valid;
   logic [2:0] Strike;
   logic [2:0] Ball;
   logic       Clear;
   logic [3:0] Green;
   logic [3:0] Red;
   logic       Win;
   logic       Busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      logic [9:0] v;
   } exp_t;

   exp_t sb[$];

   result_led_ctrl #(
      .DIGITS(4), .CNT_W(3), .BLINK_DIV(4), .WIN_BLINKS(2), .HOLD_CYCLES(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .Valid(Valid), .Strike(Strike), .Ball(Ball),
      .Clear(Clear), .Green(Green), .Red(Red), .Win(Win), .Busy(Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got G=%b R=%b W=%b B=%b, want G=%b R=%b W=%b B=%b",
                  tag, got[9:6], got[5:2], got[1], got[0],
                  exp[9:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic push_exp(input string tag, input logic [3:0] g, input logic [3:0] r,
                           input logic w, input logic b, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.tag = $sformatf("%s[%0d]", tag, i);
         e.v   = {g, r, w, b};
         sb.push_back(e);
      end
   endtask

   task automatic tick(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_val(e.tag, {Green, Red, Win, Busy}, e.v);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1; Valid = 1'b0; Strike = 3'd0; Ball = 3'd0; Clear = 1'b0;
      // Asynchronous reset before any clock edge.
      #1 rst_n = 1'b0;
      #1 chk_val("reset", {Green, Red, Win, Busy}, {4'b0000, 4'b1111, 1'b0, 1'b0});
      tick(2);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Partial result, then timeout to IDLE after exactly 10 cycles.
      Valid = 1'b1; Strike = 3'd2; Ball = 3'd1;
      push_exp("show21", 4'b0011, 4'b0001, 1'b0, 1'b0, 10);
      push_exp("timeout", 4'b0000, 4'b1111, 1'b0, 1'b0, 1);
      tick(1);
      Valid = 1'b0;
      tick(10);

      // Re-latch at cycle 5 of SHOW restarts the hold.
      Valid = 1'b1; Strike = 3'd2; Ball = 3'd1;
      push_exp("relatch_a", 4'b0011, 4'b0001, 1'b0, 1'b0, 5);
      push_exp("relatch_b", 4'b0001, 4'b0111, 1'b0, 1'b0, 10);
      push_exp("relatch_idle", 4'b0000, 4'b1111, 1'b0, 1'b0, 1);
      tick(1);
      Valid = 1'b0;
      tick(4);
      Valid = 1'b1; Strike = 3'd1; Ball = 3'd3;
      tick(1);
      Valid = 1'b0;
      tick(10);

      // Ball clamp, then Clear out of SHOW.
      Valid = 1'b1; Strike = 3'd3; Ball = 3'd7;
      push_exp("clamp_ball", 4'b0111, 4'b1111, 1'b0, 1'b0, 1);
      push_exp("clear_show", 4'b0000, 4'b1111, 1'b0, 1'b0, 1);
      tick(1);
      Valid = 1'b0; Clear = 1'b1;
      tick(1);
      Clear = 1'b0;

      // Win: two on/off periods of 4 cycles each, then solid green.
      Valid = 1'b1; Strike = 3'd4; Ball = 3'd0;
      push_exp("blink_on0", 4'b1111, 4'b0000, 1'b1, 1'b1, 4);
      push_exp("blink_off0", 4'b0000, 4'b0000, 1'b1, 1'b1, 4);
      push_exp("blink_on1", 4'b1111, 4'b0000, 1'b1, 1'b1, 4);
      push_exp("blink_off1", 4'b0000, 4'b0000, 1'b1, 1'b1, 4);
      push_exp("win_hold", 4'b1111, 4'b0000, 1'b1, 1'b0, 3);
      tick(1);
      Valid = 1'b0;
      tick(16);
      Valid = 1'b1; Strike = 3'd1; Ball = 3'd0;
      tick(1);
      Valid = 1'b0;
      tick(1);

      // Clear from WIN_HOLD, then Clear beats Valid during WIN_BLINK.
      Clear = 1'b1;
      push_exp("clear_hold", 4'b0000, 4'b1111, 1'b0, 1'b0, 1);
      tick(1);
      Clear = 1'b0;
      Valid = 1'b1; Strike = 3'd7; Ball = 3'd0;
      push_exp("win_clamp", 4'b1111, 4'b0000, 1'b1, 1'b1, 2);
      push_exp("clear_prio", 4'b0000, 4'b1111, 1'b0, 1'b0, 2);
      tick(1);
      Valid = 1'b0;
      tick(1);
      Clear = 1'b1; Valid = 1'b1; Strike = 3'd2; Ball = 3'd1;
      tick(1);
      Clear = 1'b0; Valid = 1'b0;
      tick(1);

      // Asynchronous reset in the middle of a blink.
      Valid = 1'b1; Strike = 3'd4; Ball = 3'd0;
      push_exp("pre_rst", 4'b1111, 4'b0000, 1'b1, 1'b1, 3);
      tick(1);
      Valid = 1'b0;
      tick(2);
      #2 rst_n = 1'b0;
      #1 chk_val("async_rst", {Green, Red, Win, Busy}, {4'b0000, 4'b1111, 1'b0, 1'b0});
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      Valid = 1'b1; Strike = 3'd2; Ball = 3'd1;
      push_exp("post_rst", 4'b0011, 4'b0001, 1'b0, 1'b0, 1);
      tick(1);
      Valid = 1'b0;

      chk_val("sb_drain", 10'(sb.size()), 10'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
